fifo_wr_ctrl: RTL and testbench

Write-side control for the asynchronous FIFO. It owns the binary write pointer and the memory write address, and publishes a registered Gray-coded write pointer for synchronisation into the read domain. From the synchronised Gray read pointer it derives full, almost-full, fill level and a sticky overflow flag. It sits between the producer, the dual-port FIFO memory write port and the write-to-read double-flop synchroniser.

---
 rtl/fifo_wr_ctrl.sv | 85 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer and flag logic of the asynchronous FIFO.
// Owns the binary write pointer, drives the memory write port, publishes the
// registered Gray write pointer to the read domain, and derives full,
// almost-full, fill level and sticky overflow from the synchronised Gray
// read pointer.
module fifo_wr_ctrl #(
    parameter int Pointer_Size = 4,
    parameter int AFULL_LEVEL  = 6
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic                    winc,
    input  logic [Pointer_Size-1:0] sync_r2w_ptr,
    output logic [Pointer_Size-1:0] gray_w2r_ptr,
    output logic [Pointer_Size-2:0] waddr,
    output logic                    wclken,
    output logic                    wfull,
    output logic                    walmost_full,
    output logic [Pointer_Size-1:0] wlevel,
    output logic                    woverflow
);

    localparam int P = Pointer_Size;
    localparam logic [P-1:0] ONE       = P'(1);
    localparam logic [P-1:0] AFULL_THR = P'(AFULL_LEVEL);

    function automatic logic [P-1:0] bin2gray(input logic [P-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // XOR prefix from the MSB down turns a Gray code back into binary.
    function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
        logic [P-1:0] b;
        b[P-1] = g[P-1];
        for (int i = P - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [P-1:0] wptr;
    logic [P-1:0] wptr_next;
    logic [P-1:0] wgray_next;
    logic [P-1:0] rbin;
    logic [P-1:0] wlevel_next;
    logic         wfull_next;
    logic         wafull_next;

    // Reset gates the write enable so a reset arriving mid-burst never writes.
    assign wclken = winc & ~wfull & ~wrst;
    assign waddr  = wptr[P-2:0];

    // Next pointer and every flag come from one wptr_next / sync_r2w_ptr
    // sample, so level, full and almost-full can never disagree.
    always_comb begin
        wptr_next   = wclken ? (wptr + ONE) : wptr;
        wgray_next  = bin2gray(wptr_next);
        rbin        = gray2bin(sync_r2w_ptr);
        wlevel_next = wptr_next - rbin;
        // Full when the write pointer is one lap ahead: top two Gray bits
        // inverted, the rest equal.
        wfull_next  = (wgray_next == {~sync_r2w_ptr[P-1:P-2], sync_r2w_ptr[P-3:0]});
        wafull_next = (wlevel_next >= AFULL_THR);
    end

    // Pointer, published Gray pointer and flags all update on the same edge.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr         <= '0;
            gray_w2r_ptr <= '0;
            wlevel       <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            woverflow    <= 1'b0;
        end else begin
            wptr         <= wptr_next;
            gray_w2r_ptr <= wgray_next;
            wlevel       <= wlevel_next;
            wfull        <= wfull_next;
            walmost_full <= wafull_next;
            woverflow    <= woverflow | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed plus randomized bench for fifo_wr_ctrl.
// The reference model counts accepted writes and reads as plain integers;
// occupancy is their difference, full is occupancy == depth.
module tb_fifo_wr_ctrl;

    localparam int P     = 4;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic         wclk = 1'b0;
    logic         wrst = 1'b1;
    logic         winc = 1'b0;
    logic [P-1:0] sync_r2w_ptr = '0;
    logic [P-1:0] gray_w2r_ptr;
    logic [P-2:0] waddr;
    logic         wclken;
    logic         wfull;
    logic         walmost_full;
    logic [P-1:0] wlevel;
    logic         woverflow;

    fifo_wr_ctrl #(
        .Pointer_Size(P),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .sync_r2w_ptr(sync_r2w_ptr),
        .gray_w2r_ptr(gray_w2r_ptr),
        .waddr       (waddr),
        .wclken      (wclken),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow)
    );

    always #5 wclk = ~wclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int   m_wr   = 0;
    int   m_rd   = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;
    logic [P-1:0] prev_gray = '0;

    function automatic logic [P-1:0] to_gray(input int cnt);
        logic [P-1:0] v;
        v = cnt[P-1:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive after the falling edge, check the
    // combinational enable, then check registered outputs 1ns after the edge.
    task automatic step(input logic r_i, input logic w_i, input logic rd_i);
        logic exp_en;
        int   lvl;
        @(negedge wclk);
        wrst = r_i;
        winc = w_i;
        if (r_i) m_rd = 0;
        else if (rd_i) m_rd++;
        sync_r2w_ptr = to_gray(m_rd);
        exp_en = w_i & ~m_full & ~r_i;
        #1;
        chk("wclken", wclken, exp_en);
        prev_gray = gray_w2r_ptr;
        @(posedge wclk);
        #1;
        if (r_i) begin
            m_wr  = 0;
            m_ovf = 1'b0;
        end else begin
            m_ovf = m_ovf | (w_i & m_full);
            if (exp_en) m_wr++;
        end
        lvl    = m_wr - m_rd;
        m_full = (lvl == DEPTH);
        chk("wlevel",       wlevel,       lvl);
        chk("wfull",        wfull,        m_full);
        chk("walmost_full", walmost_full, (lvl >= AFULL));
        chk("woverflow",    woverflow,    m_ovf);
        chk("gray_w2r_ptr", gray_w2r_ptr, to_gray(m_wr));
        chk("waddr",        waddr,        m_wr % DEPTH);
        if (!r_i) chk("gray_one_bit", $countones(gray_w2r_ptr ^ prev_gray), exp_en ? 1 : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int lvl;
        logic w, r;

        // Reset with winc high, then idle
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Fill eight slots with the read pointer parked at zero
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0);
        chk("fill_gray",  gray_w2r_ptr, 4'b1100);
        chk("fill_level", wlevel,       8);
        chk("fill_full",  wfull,        1'b1);

        // Writes while full are dropped and set overflow
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        chk("ovf_gray", gray_w2r_ptr, 4'b1100);
        chk("ovf_flag", woverflow,    1'b1);

        // Drain two entries
        step(1'b0, 1'b0, 1'b1);
        chk("drain1_sync",  sync_r2w_ptr, 4'b0001);
        chk("drain1_full",  wfull,        1'b0);
        chk("drain1_level", wlevel,       7);
        chk("drain1_afull", walmost_full, 1'b1);
        chk("drain1_ovf",   woverflow,    1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("drain2_sync",  sync_r2w_ptr, 4'b0011);
        chk("drain2_level", wlevel,       6);

        // Refill to 8, then write and read together while full
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("refill_full", wfull, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("simul_level", wlevel, 7);
        chk("simul_full",  wfull,  1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("simul_refull", wfull, 1'b1);

        // Drain down to 3 entries
        while (m_wr - m_rd > 3) step(1'b0, 1'b0, 1'b1);

        // Randomized wrap-around: 40 writes, occupancy kept in 1..5
        accepted = 0;
        for (int it = 0; it < 400 && accepted < 40; it++) begin
            lvl = m_wr - m_rd;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (lvl + int'(w) - int'(r) > 5) r = 1'b1;
            if (lvl + int'(w) - int'(r) > 5) w = 1'b0;
            if (lvl + int'(w) - int'(r) < 1) r = 1'b0;
            step(1'b0, w, r);
            if (w) accepted++;
            chk("wrap_nofull", wfull, 1'b0);
        end
        chk("wrap_count", accepted, 40);

        // Reset in the middle of a write burst
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("mrst_gray",  gray_w2r_ptr, 0);
        chk("mrst_ovf",   woverflow,    1'b0);
        chk("mrst_level", wlevel,       0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("post_rst_waddr", waddr, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
